// File: rtl/pipelined_add_sub_pkg.sv
// Shared opcodes and parameter sanity check for the pipelined add/sub unit.
`ifndef PIPELINED_ADD_SUB_CHECK
`define PIPELINED_ADD_SUB_CHECK
`define PAS_CHECK_PARAMS(w, s) \
  if (((s) < 1) || (((w) % (s)) != 0)) begin : g_bad_params \
    $error("pipelined_add_sub: WIDTH must be a positive multiple of SEG"); \
  end
`endif

package pipelined_add_sub_pkg;
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;
endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell, the building block of the ripple segments.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/pipelined_add_sub_add_segment.sv
// Combinational SEG-bit ripple chain; also exposes the carry into its MSB.
module add_segment #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           carry_msb
);
  logic [SEG:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign cout      = c[SEG];
  assign carry_msb = c[SEG-1];
endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined add/subtract: one SEG-bit segment resolved per stage, carry
// registered between stages, whole-pipeline valid/ready enable.
module pipelined_add_sub
  import pipelined_add_sub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / SEG;

  `PAS_CHECK_PARAMS(WIDTH, SEG)

  logic                          advance;
  logic [WIDTH-1:0]              b_eff;
  logic                          c0;

  logic [STAGES-1:0]             v_q, c_q;
  logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, s_q;
  logic                          cmsb_q;

  logic [STAGES-1:0]             stg_v, stg_c;
  logic [STAGES-1:0][WIDTH-1:0]  stg_a, stg_b, stg_s, nxt_s;
  logic [STAGES-1:0][SEG-1:0]    seg_sum;
  logic [STAGES-1:0]             seg_cout, seg_cmsb;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign b_eff = (sub == SUB) ? ~b : b;
  assign c0    = (sub == SUB) ? ~cin : cin;

  // Stage k sees the raw conditioned operands (k=0) or the previous stage's registers.
  always_comb begin
    stg_v[0] = in_valid;
    stg_c[0] = c0;
    stg_a[0] = a;
    stg_b[0] = b_eff;
    stg_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      stg_v[k] = v_q[k-1];
      stg_c[k] = c_q[k-1];
      stg_a[k] = a_q[k-1];
      stg_b[k] = b_q[k-1];
      stg_s[k] = s_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      nxt_s[k] = stg_s[k];
      nxt_s[k][k*SEG +: SEG] = seg_sum[k];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    add_segment #(.SEG(SEG)) u_seg (
      .a         (stg_a[k][k*SEG +: SEG]),
      .b         (stg_b[k][k*SEG +: SEG]),
      .cin       (stg_c[k]),
      .sum       (seg_sum[k]),
      .cout      (seg_cout[k]),
      .carry_msb (seg_cmsb[k])
    );
  end

  // Data only loads behind a valid beat, so bubbles leave the outputs untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      c_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      s_q    <= '0;
      cmsb_q <= 1'b0;
    end else if (advance) begin
      v_q <= stg_v;
      for (int k = 0; k < STAGES; k++) begin
        if (stg_v[k]) begin
          a_q[k] <= stg_a[k];
          b_q[k] <= stg_b[k];
          c_q[k] <= seg_cout[k];
          s_q[k] <= nxt_s[k];
        end
      end
      if (stg_v[STAGES-1]) begin
        cmsb_q <= seg_cmsb[STAGES-1];
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = cmsb_q ^ c_q[STAGES-1];
endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed bench for pipelined_add_sub (WIDTH=32, SEG=8): vector table,
// streaming, back-pressure and mid-stream reset sequences.
module tb_pipelined_add_sub;
  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, sum;
  logic        cin, sub, cout, ovf;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  pipelined_add_sub #(.WIDTH(32), .SEG(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  // Independent reference: 33-bit add of conditioned operands, sign-rule overflow.
  function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mcin, input logic msub);
    logic [31:0] be;
    logic [32:0] r;
    logic        ov;
    be = msub ? ~mb : mb;
    r  = {1'b0, ma} + {1'b0, be} + {32'd0, msub ? ~mcin : mcin};
    ov = (ma[31] == be[31]) && (r[31] != ma[31]);
    return {ov, r[32], r[31:0]};
  endfunction

  task automatic apply_stimulus(input vec_t v, input string tag);
    int cyc;
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_output({tag, " latency"}, cyc, 4);
    check_output({tag, " sum"}, sum, v.sum);
    check_output({tag, " cout"}, {31'd0, cout}, {31'd0, v.cout});
    check_output({tag, " ovf"}, {31'd0, ovf}, {31'd0, v.ovf});
    @(posedge clk); #1;
    check_output({tag, " single valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Streams n beats; stalls out_ready for stall_len cycles once stall_after beats drained.
  task automatic run_stream(input int n, input int stall_after, input int stall_len,
                            input string tag);
    logic [33:0] q[$];
    logic [33:0] exp_v;
    int sent = 0, recv = 0, cyc = 0, stalled = 0;
    int first_out = -1, last_out = -1, valid_cycles = 0, ready_low = 0;
    while (recv < n && cyc < 300) begin
      a   = 32'h89AB_CDEF + 32'(sent) * 32'h1357_9BDF;
      b   = ~(32'(sent) * 32'h2468_ACE1);
      sub = sent[0];
      cin = sent[1];
      in_valid  = (sent < n);
      out_ready = !(out_valid && recv >= stall_after && stalled < stall_len);
      #1;
      if (out_valid) begin
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        valid_cycles++;
        if (q.size() == 0) begin
          check_output({tag, " unexpected beat"}, 32'd1, 32'd0);
        end else begin
          exp_v = q[0];
          check_output({tag, " sum"}, sum, exp_v[31:0]);
          if (out_ready) begin
            check_output({tag, " cout"}, {31'd0, cout}, {31'd0, exp_v[32]});
            check_output({tag, " ovf"}, {31'd0, ovf}, {31'd0, exp_v[33]});
            void'(q.pop_front());
            recv++;
          end else begin
            check_output({tag, " in_ready stall"}, {31'd0, in_ready}, 32'd0);
            stalled++;
          end
        end
      end
      if (in_valid && !in_ready && out_ready) ready_low++;
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, cin, sub));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_output({tag, " beats received"}, recv, n);
    check_output({tag, " leftover"}, q.size(), 0);
    check_output({tag, " stall cycles"}, stalled, stall_len);
    check_output({tag, " in_ready drops"}, ready_low, 0);
    if (stall_len == 0) begin
      check_output({tag, " first out cycle"}, first_out, 4);
      check_output({tag, " valid span"}, last_out - first_out + 1, n);
      check_output({tag, " valid cycles"}, valid_cycles, n);
    end
  endtask

  initial begin
    int stale;
    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
    vecs[6] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_output("reset out_valid", {31'd0, out_valid}, 32'd0);
    check_output("reset sum", sum, 32'd0);
    check_output("reset cout", {31'd0, cout}, 32'd0);
    check_output("reset ovf", {31'd0, ovf}, 32'd0);
    check_output("reset in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i], $sformatf("vec%0d", i));

    run_stream(16, 0, 0, "stream");
    run_stream(10, 2, 5, "backpressure");

    // Reset with three beats in flight and a fourth presenting at the output.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'hFFFF_FFFF; b = 32'h1111_1111; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_output("pre-reset out_valid", {31'd0, out_valid}, 32'd1);
    check_output("pre-reset sum", sum, 32'h1111_1110);
    #2 rst_n = 1'b0;
    #1;
    check_output("async reset out_valid", {31'd0, out_valid}, 32'd0);
    check_output("async reset sum", sum, 32'd0);
    check_output("async reset cout", {31'd0, cout}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    check_output("stale beats after reset", stale, 0);
    apply_stimulus(vecs[6], "post-reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
